// File: rtl/seq_slice_adder.sv
// -----------------------------------------------------------------------------
// seq_slice_adder
//
// Multi-cycle WIDTH-bit adder/subtractor. The operation ripples through
// SLICE-bit full-adder slices, one slice per clock, LSB slice first, so the
// longest combinational path is a single SLICE-bit carry chain.
//
// Ports
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request; accepted on an edge where start && ready
//   a      in   operand X (sampled at acceptance)
//   b      in   operand Y (sampled at acceptance)
//   cin    in   carry/borrow in (sampled at acceptance)
//   sub    in   0: a+b+cin, 1: a-b-cin (sampled at acceptance)
//   ready  out  block can accept start this cycle (IDLE or DONE)
//   busy   out  operation in progress (RUN)
//   done   out  one-cycle pulse, result outputs just updated
//   sum    out  registered result
//   cout   out  raw carry out of the MSB (for sub: 1 = no borrow)
//   ovf    out  signed two's-complement overflow
//   zero   out  sum == 0
// -----------------------------------------------------------------------------
module seq_slice_adder #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NSLICE = WIDTH / ((SLICE < 1) ? 1 : SLICE);
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if (SLICE < 1 || SLICE > WIDTH || (WIDTH % ((SLICE < 1) ? 1 : SLICE)) != 0) begin : g_bad_params
            $error("seq_slice_adder: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_q;        // operand X captured at acceptance
    logic [WIDTH-1:0]  b_q;        // effective operand Y (inverted for sub)
    logic [WIDTH-1:0]  partial;    // slices computed so far
    logic              carry;      // carry between slices
    logic [CW-1:0]     idx;        // slice currently being processed

    logic [SLICE-1:0]  a_sl;
    logic [SLICE-1:0]  b_sl;
    logic [SLICE-1:0]  s_sl;
    logic              c_sl;
    logic              last;
    logic              ovf_next;
    logic [WIDTH-1:0]  full_sum;

    // Handshake outputs decode straight from the state register.
    assign ready = (state != RUN);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

    // One slice of the ripple chain.
    always_comb begin
        // NOTE: every variable gets a value before any partial overwrite, so no
        // path leaves one unassigned and no latch is inferred.
        full_sum = partial;
        a_sl     = a_q[idx*SLICE +: SLICE];
        b_sl     = b_q[idx*SLICE +: SLICE];
        {c_sl, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry};
        last     = (idx == CW'(NSLICE - 1));
        // Carry into the MSB recovered from the MSB's own sum bit.
        ovf_next = (a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ s_sl[SLICE-1]) ^ c_sl;
        // Final result is the earlier slices plus the one being added now.
        full_sum[idx*SLICE +: SLICE] = s_sl;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            partial <= '0;
            carry   <= 1'b0;
            idx     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_q   <= a;
                        // Subtraction is a + ~b + 1; the +1 folds into the carry,
                        // and a borrow-in removes it again.
                        b_q   <= sub ? ~b : b;
                        carry <= cin ^ sub;
                        idx   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    partial[idx*SLICE +: SLICE] <= s_sl;
                    carry <= c_sl;
                    if (last) begin
                        sum   <= full_sum;
                        cout  <= c_sl;
                        ovf   <= ovf_next;
                        zero  <= (full_sum == '0);
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_slice_adder.sv
// -----------------------------------------------------------------------------
// tb_seq_slice_adder
//
// Three instances (32/8, 8/8, 12/4) share operand inputs and reset. A model
// computes each result from plain signed/unsigned arithmetic and predicts
// acceptance and done timing from the documented latency; a single negedge
// process compares all outputs of every instance each cycle. Directed
// operations additionally pin results and latencies to literal values.
// -----------------------------------------------------------------------------
module tb_seq_slice_adder;

    localparam int NS [3] = '{4, 1, 3};
    localparam int WV [3] = '{32, 8, 12};

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  start = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;

    logic [2:0]  ready, busy, done, cout, ovf, zero;
    logic [31:0] sum32;
    logic [7:0]  sum8;
    logic [11:0] sum12;
    logic [31:0] sum_w [3];

    assign sum_w[0] = sum32;
    assign sum_w[1] = {24'h0, sum8};
    assign sum_w[2] = {20'h0, sum12};

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   next_ok [3] = '{0, 0, 0};
    bit   pend [3] = '{0, 0, 0};
    exp_t pend_exp [3];
    exp_t last_exp [3];

    seq_slice_adder #(.WIDTH(32), .SLICE(8)) u_a32 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .a(a), .b(b), .cin(cin), .sub(sub),
        .ready(ready[0]), .busy(busy[0]), .done(done[0]), .sum(sum32),
        .cout(cout[0]), .ovf(ovf[0]), .zero(zero[0]));

    seq_slice_adder #(.WIDTH(8), .SLICE(8)) u_a8 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
        .ready(ready[1]), .busy(busy[1]), .done(done[1]), .sum(sum8),
        .cout(cout[1]), .ovf(ovf[1]), .zero(zero[1]));

    seq_slice_adder #(.WIDTH(12), .SLICE(4)) u_a12 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .a(a[11:0]), .b(b[11:0]), .cin(cin), .sub(sub),
        .ready(ready[2]), .busy(busy[2]), .done(done[2]), .sum(sum12),
        .cout(cout[2]), .ovf(ovf[2]), .zero(zero[2]));

    always #5 clk = ~clk;

    // Reference arithmetic: exact signed and unsigned results, then reduce.
    function automatic exp_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                   input logic ci, input logic sop);
        exp_t   r;
        longint m    = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint ua   = longint'(av) & m;
        longint ub   = longint'(bv) & m;
        longint sa   = (ua >= half) ? ua - 2 * half : ua;
        longint sb   = (ub >= half) ? ub - 2 * half : ub;
        longint ur, sr;
        if (!sop) begin
            ur     = ua + ub + longint'(ci);
            sr     = sa + sb + longint'(ci);
            r.cout = (ur >= 2 * half);
        end else begin
            ur     = ua - ub - longint'(ci);
            sr     = sa - sb - longint'(ci);
            r.cout = (ur >= 0);
        end
        r.sum  = 32'(ur & m);
        r.ovf  = (sr >= half) || (sr < -half);
        r.zero = ((ur & m) == 0);
        r.due  = 0;
        return r;
    endfunction

    // Acceptance model: an instance is free again NSLICE+1 edges after it
    // accepted, i.e. in its DONE cycle.
    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (rst_n && start[i] && cyc >= next_ok[i]) begin
                pend_exp[i]     = model(WV[i], a, b, cin, sub);
                pend_exp[i].due = cyc + NS[i];
                pend[i]         = 1'b1;
                next_ok[i]      = cyc + NS[i] + 1;
            end
        end
    end

    // Cycle-by-cycle comparison of every output of every instance.
    always @(negedge clk) begin
        bit ed, eb;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                pend[i]     = 1'b0;
                next_ok[i]  = 0;
                last_exp[i] = '{sum: '0, cout: 1'b0, ovf: 1'b0, zero: 1'b0, due: 0};
            end
            ed = pend[i] && (pend_exp[i].due == cyc);
            if (ed) begin
                last_exp[i] = pend_exp[i];
                pend[i]     = 1'b0;
            end
            eb = pend[i];
            n_vec++;
            if (done[i] !== ed || busy[i] !== eb || ready[i] !== !eb ||
                sum_w[i] !== last_exp[i].sum || cout[i] !== last_exp[i].cout ||
                ovf[i] !== last_exp[i].ovf || zero[i] !== last_exp[i].zero) begin
                n_err++;
                $display("FAIL cycle_cmp dut%0d cyc%0d: got done=%b busy=%b ready=%b sum=%h cout=%b ovf=%b zero=%b, want done=%b busy=%b ready=%b sum=%h cout=%b ovf=%b zero=%b",
                         i, cyc, done[i], busy[i], ready[i], sum_w[i], cout[i], ovf[i], zero[i],
                         ed, eb, !eb, last_exp[i].sum, last_exp[i].cout, last_exp[i].ovf, last_exp[i].zero);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, got, exp);
        end
    endtask

    // Waits (bounded) for done on one instance; returns the cycle it was seen.
    task automatic wait_done(input int id, input bit disturb, output int at_cyc);
        bit seen = 1'b0;
        at_cyc = -1;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (done[id]) begin
                seen   = 1'b1;
                at_cyc = cyc;
            end else if (disturb) begin
                #1;
                a          = $urandom;
                b          = $urandom;
                cin        = 1'($urandom_range(0, 1));
                sub        = 1'($urandom_range(0, 1));
                start[id]  = ~start[id];
            end
        end
        start[id] = 1'b0;
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout dut%0d: got no done, want done within 40 cycles", id);
        end
    endtask

    task automatic run_op(input int id, input logic [31:0] av, input logic [31:0] bv,
                          input logic ci, input logic sop, input bit disturb, output int lat);
        int acc, dc;
        @(negedge clk);
        #1;
        a = av; b = bv; cin = ci; sub = sop;
        start[id] = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        start[id] = 1'b0;
        wait_done(id, disturb, dc);
        lat = (dc < 0) ? -1 : dc - acc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish before 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, d1, d2;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(ready), 64'h7);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_sum32", 64'(sum32), 64'h0);
        #1 rst_n = 1'b1;

        // 32/8: wrap to zero
        run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, lat);
        check("wrap_lat", 64'(lat), 64'd4);
        check("wrap_sum", 64'(sum32), 64'h0);
        check("wrap_flags", 64'({cout[0], ovf[0], zero[0]}), 64'b101);

        // 32/8: signed overflow, then back-to-back subtract
        run_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, lat);
        check("povf_sum", 64'(sum32), 64'h8000_0000);
        check("povf_flags", 64'({cout[0], ovf[0], zero[0]}), 64'b010);
        d1 = cyc;
        #1;
        a = 32'h8000_0000; b = 32'h0000_0001; cin = 1'b0; sub = 1'b1;
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        wait_done(0, 1'b0, d2);
        check("b2b_gap", 64'(d2 - d1), 64'd5);
        check("nsub_sum", 64'(sum32), 64'h7FFF_FFFF);
        check("nsub_flags", 64'({cout[0], ovf[0], zero[0]}), 64'b110);

        // 8/8: subtract with borrow
        run_op(1, 32'h05, 32'h03, 1'b1, 1'b1, 1'b0, lat);
        check("b8_lat", 64'(lat), 64'd1);
        check("b8_sum", 64'(sum8), 64'h01);
        check("b8_flags", 64'({cout[1], ovf[1], zero[1]}), 64'b100);
        run_op(1, 32'h00, 32'h01, 1'b0, 1'b1, 1'b0, lat);
        check("u8_sum", 64'(sum8), 64'hFF);
        check("u8_cout", 64'(cout[1]), 64'h0);

        // 12/4
        run_op(2, 32'hABC, 32'h544, 1'b1, 1'b0, 1'b0, lat);
        check("w12_lat", 64'(lat), 64'd3);
        check("w12_sum", 64'(sum12), 64'h001);
        check("w12_cout", 64'(cout[2]), 64'h1);

        // Inputs and start toggled during RUN must not matter
        run_op(0, 32'h0000_1000, 32'h0000_0234, 1'b0, 1'b0, 1'b1, lat);
        check("dist_lat", 64'(lat), 64'd4);
        check("dist_sum", 64'(sum32), 64'h0000_1234);

        // Reset during slice 2 of a running add
        @(negedge clk);
        #1;
        a = 32'h1111_1111; b = 32'h2222_2222; cin = 1'b0; sub = 1'b0;
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_ready", 64'(ready[0]), 64'h1);
        check("abort_busy", 64'(busy[0]), 64'h0);
        check("abort_sum", 64'(sum32), 64'h0);
        check("abort_flags", 64'({cout[0], ovf[0], zero[0]}), 64'b000);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("abort_nodone", 64'(done[0]), 64'h0);
        end
        run_op(0, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 1'b0, lat);
        check("fresh_lat", 64'(lat), 64'd4);
        check("fresh_sum", 64'(sum32), 64'h0000_000D);

        // Random operations across all three instances
        for (int i = 0; i < 1000; i++) begin
            int id = i % 3;
            run_op(id, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   (i % 7) == 0, lat);
            check("rand_lat", 64'(lat), 64'(NS[id]));
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
